// File: rtl/ptp_ts_fifo.sv
// ptp_ts_fifo: DEPTH-entry queue of PTP timestamp records, drained by software as seven 32-bit words.
// Optional `PTP_TS_FIFO_MSG_FILTER_EN adds msg_filter_i, a per-messageType write enable mask.
module ptp_ts_fifo #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AW         = 3,
    parameter int unsigned INT_THRESH = 1
) (
    input  logic          rtc_clk,
    input  logic          rtc_rst_n,
    input  logic          wr_en_i,
    input  logic [79:0]   ts_i,
    input  logic [15:0]   ts_frac_ns_i,
    input  logic [79:0]   src_port_id_i,
    input  logic [15:0]   seq_id_i,
    input  logic [15:0]   flag_field_i,
    input  logic [3:0]    msg_type_i,
    input  logic [3:0]    major_sdo_id_i,
    input  logic          rd_word_i,
    input  logic          clr_i,
`ifdef PTP_TS_FIFO_MSG_FILTER_EN
    input  logic [15:0]   msg_filter_i,
`endif
    output logic [31:0]   rd_data_o,
    output logic [2:0]    rd_word_idx_o,
    output logic [AW:0]   level_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [15:0]   ovf_cnt_o,
    output logic          int_o
);

    localparam int unsigned LW         = AW + 1;
    localparam logic [2:0]  LAST_WORD  = 3'd6;
    localparam logic [AW:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [AW:0] LEVEL_INT  = LW'(INT_THRESH);

    typedef logic [6:0][31:0] rec_t;

    rec_t          mem [DEPTH];
    rec_t          wr_rec;
    rec_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_cand;
    logic          rd_adv;
    logic          pop;
    logic          push;
    logic          drop;

    // Concatenation lists w6 first so that wr_rec[k] holds word k.
    assign wr_rec = {
        {flag_field_i, 8'h00, major_sdo_id_i, msg_type_i},
        {src_port_id_i[15:0], seq_id_i},
        src_port_id_i[47:16],
        src_port_id_i[79:48],
        {ts_i[15:0], ts_frac_ns_i},
        ts_i[47:16],
        ts_i[79:48]
    };

`ifdef PTP_TS_FIFO_MSG_FILTER_EN
    assign wr_cand = wr_en_i & msg_filter_i[msg_type_i];
`else
    assign wr_cand = wr_en_i;
`endif

    assign empty_o = (level_o == '0);
    assign full_o  = (level_o == LEVEL_FULL);
    assign int_o   = (level_o >= LEVEL_INT);

    // A pop on the final word frees a slot in the same cycle, so a write while full can still land.
    assign rd_adv = rd_word_i & ~empty_o & ~clr_i;
    assign pop    = rd_adv & (rd_word_idx_o == LAST_WORD);
    assign push   = wr_cand & ~clr_i & (~full_o | pop);
    assign drop   = wr_cand & ~clr_i & full_o & ~pop;

    always_ff @(posedge rtc_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
        if (!rtc_rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level_o       <= '0;
            rd_word_idx_o <= '0;
            ovf_cnt_o     <= '0;
        end else if (clr_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level_o       <= '0;
            rd_word_idx_o <= '0;
            ovf_cnt_o     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (rd_adv) begin
                rd_word_idx_o <= pop ? 3'd0 : rd_word_idx_o + 3'd1;
            end
            if (push && !pop) begin
                level_o <= level_o + 1'b1;
            end else if (pop && !push) begin
                level_o <= level_o - 1'b1;
            end
            if (drop && (ovf_cnt_o != 16'hFFFF)) begin
                ovf_cnt_o <= ovf_cnt_o + 16'd1;
            end
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        rd_data_o = '0;
        if (!empty_o && (rd_word_idx_o <= LAST_WORD)) begin
            rd_data_o = head[rd_word_idx_o];
        end
    end

endmodule

// File: tb/tb_ptp_ts_fifo.sv
// Scoreboard bench for ptp_ts_fifo: expected records queued at write time, compared word by word on read-out.
module tb_ptp_ts_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned THR   = 3;

    typedef struct packed {
        logic [79:0] ts;
        logic [15:0] frac;
        logic [79:0] spid;
        logic [15:0] seq;
        logic [15:0] flag;
        logic [3:0]  msg;
        logic [3:0]  sdo;
    } rec_t;

    logic        rtc_clk = 1'b0;
    logic        rtc_rst_n;
    logic        wr_en;
    logic        rd_word;
    logic        clr;
    rec_t        din;
`ifdef PTP_TS_FIFO_MSG_FILTER_EN
    logic [15:0] msg_filter;
`endif
    logic [31:0] rd_data;
    logic [2:0]  rd_idx;
    logic [AW:0] level;
    logic        empty;
    logic        full;
    logic [15:0] ovf_cnt;
    logic        int_flag;

    rec_t        sb[$];
    int unsigned exp_idx;
    logic [15:0] movf;
    int          tests;
    int          fails;

    always #5 rtc_clk = ~rtc_clk;

    ptp_ts_fifo #(.DEPTH(DEPTH), .AW(AW), .INT_THRESH(THR)) dut (
        .rtc_clk        (rtc_clk),
        .rtc_rst_n      (rtc_rst_n),
        .wr_en_i        (wr_en),
        .ts_i           (din.ts),
        .ts_frac_ns_i   (din.frac),
        .src_port_id_i  (din.spid),
        .seq_id_i       (din.seq),
        .flag_field_i   (din.flag),
        .msg_type_i     (din.msg),
        .major_sdo_id_i (din.sdo),
        .rd_word_i      (rd_word),
        .clr_i          (clr),
`ifdef PTP_TS_FIFO_MSG_FILTER_EN
        .msg_filter_i   (msg_filter),
`endif
        .rd_data_o      (rd_data),
        .rd_word_idx_o  (rd_idx),
        .level_o        (level),
        .empty_o        (empty),
        .full_o         (full),
        .ovf_cnt_o      (ovf_cnt),
        .int_o          (int_flag)
    );

    function automatic logic [31:0] word_of(input rec_t r, input int unsigned k);
        case (k)
            0:       return r.ts[79:48];
            1:       return r.ts[47:16];
            2:       return {r.ts[15:0], r.frac};
            3:       return r.spid[79:48];
            4:       return r.spid[47:16];
            5:       return {r.spid[15:0], r.seq};
            6:       return {r.flag, 8'h00, r.sdo, r.msg};
            default: return 32'h0;
        endcase
    endfunction

    function automatic rec_t mk(input logic [15:0] seq, input logic [3:0] msg);
        rec_t r;
        r.ts   = {$urandom, $urandom, 16'($urandom)};
        r.frac = 16'($urandom);
        r.spid = {$urandom, $urandom, 16'($urandom)};
        r.seq  = seq;
        r.flag = 16'($urandom);
        r.msg  = msg;
        r.sdo  = 4'($urandom);
        return r;
    endfunction

    // One clock of stimulus; the reference model advances alongside.
    task automatic cycle(input logic wr, input logic rd, input logic cl, input rec_t r);
        bit wcand, adv, pop, fullm;
        wr_en = wr; rd_word = rd; clr = cl; din = r;
        wcand = wr;
`ifdef PTP_TS_FIFO_MSG_FILTER_EN
        wcand = wr && msg_filter[r.msg];
`endif
        if (cl) begin
            sb.delete(); exp_idx = 0; movf = '0;
        end else begin
            fullm = (sb.size() == DEPTH);
            adv   = rd && (sb.size() != 0);
            pop   = adv && (exp_idx == 6);
            if (adv) exp_idx = pop ? 0 : exp_idx + 1;
            if (pop) void'(sb.pop_front());
            if (wcand) begin
                if (!fullm || pop) sb.push_back(r);
                else if (movf != 16'hFFFF) movf = movf + 16'd1;
            end
        end
        @(posedge rtc_clk); #1;
        wr_en = 1'b0; rd_word = 1'b0; clr = 1'b0;
    endtask

    task automatic drain_one(input string tag);
        for (int k = 0; k < 7; k++) begin
            tests++;
            if (sb.size() == 0 || rd_data !== word_of(sb[0], exp_idx) || rd_idx !== 3'(exp_idx)) begin
                fails++;
                $display("FAIL %s word%0d: got data=%h idx=%0d, want data=%h idx=%0d", tag, k, rd_data, rd_idx,
                         (sb.size() != 0) ? word_of(sb[0], exp_idx) : 32'h0, exp_idx);
            end
            cycle(1'b0, 1'b1, 1'b0, '0);
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({level, empty, full, int_flag, rd_data, rd_idx, ovf_cnt} !== {4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0, 16'h0}) begin
            fails++;
            $display("FAIL reset: got lvl=%0d e=%b f=%b int=%b data=%h idx=%0d ovf=%0d, want 0 1 0 0 0 0 0",
                     level, empty, full, int_flag, rd_data, rd_idx, ovf_cnt);
        end
    endtask

    task automatic test_single_record();
        rec_t r;
        r = mk(16'h0007, 4'h0);
        r.ts = 80'h0000_0000_0001_1234_5678;
        r.frac = 16'hABCD;
        cycle(1'b1, 1'b0, 1'b0, r);
        tests++;
        if (level !== 4'd1 || empty !== 1'b0) begin
            fails++; $display("FAIL single_status: got lvl=%0d e=%b, want 1 0", level, empty);
        end
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        tests++;
        if (rd_data !== 32'h5678ABCD) begin
            fails++; $display("FAIL single_w2: got %h, want 5678abcd", rd_data);
        end
        for (int k = 2; k < 7; k++) begin
            tests++;
            if (rd_data !== word_of(r, k) || rd_idx !== 3'(k)) begin
                fails++; $display("FAIL single_w%0d: got %h idx=%0d, want %h", k, rd_data, rd_idx, word_of(r, k));
            end
            cycle(1'b0, 1'b1, 1'b0, '0);
        end
        tests++;
        if (empty !== 1'b1 || rd_data !== 32'h0 || level !== 4'd0) begin
            fails++; $display("FAIL single_empty: got e=%b data=%h lvl=%0d, want 1 0 0", empty, rd_data, level);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, mk(16'(i), 4'(i)));
        tests++;
        if (full !== 1'b1 || level !== 4'd8 || ovf_cnt !== 16'd2 || int_flag !== 1'b1) begin
            fails++; $display("FAIL overflow: got f=%b lvl=%0d ovf=%0d int=%b, want 1 8 2 1", full, level, ovf_cnt, int_flag);
        end
        for (int i = 0; i < 8; i++) drain_one("overflow_drain");
    endtask

    task automatic test_full_pop_push();
        rec_t nr;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, mk(16'(16'h40 + i), 4'h3));
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 1'b0, '0);
        tests++;
        if (rd_idx !== 3'd6 || rd_data !== word_of(sb[0], 6)) begin
            fails++; $display("FAIL fpp_idx6: got idx=%0d data=%h, want 6 %h", rd_idx, rd_data, word_of(sb[0], 6));
        end
        nr = mk(16'h00AA, 4'h5);
        cycle(1'b1, 1'b1, 1'b0, nr);
        tests++;
        if (level !== 4'd8 || full !== 1'b1 || ovf_cnt !== movf || ovf_cnt !== 16'd2) begin
            fails++; $display("FAIL fpp_status: got lvl=%0d f=%b ovf=%0d, want 8 1 2", level, full, ovf_cnt);
        end
        for (int i = 0; i < 8; i++) drain_one("fpp_drain");
    endtask

    task automatic test_clear();
        cycle(1'b1, 1'b0, 1'b0, mk(16'h0100, 4'h1));
        cycle(1'b1, 1'b0, 1'b0, mk(16'h0101, 4'h1));
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, '0);
        tests++;
        if (rd_idx !== 3'd3) begin
            fails++; $display("FAIL clear_pre: got idx=%0d, want 3", rd_idx);
        end
        cycle(1'b1, 1'b1, 1'b1, mk(16'h0102, 4'h1));
        tests++;
        if (level !== 4'd0 || rd_idx !== 3'd0 || ovf_cnt !== 16'd0 || empty !== 1'b1 || rd_data !== 32'h0) begin
            fails++; $display("FAIL clear: got lvl=%0d idx=%0d ovf=%0d e=%b data=%h, want 0 0 0 1 0",
                              level, rd_idx, ovf_cnt, empty, rd_data);
        end
        cycle(1'b0, 1'b0, 1'b0, '0);
        tests++;
        if (level !== 4'd0) begin
            fails++; $display("FAIL clear_nostore: got lvl=%0d, want 0", level);
        end
    endtask

    task automatic test_empty_read();
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, '0);
        tests++;
        if (rd_idx !== 3'd0 || level !== 4'd0 || empty !== 1'b1) begin
            fails++; $display("FAIL empty_read: got idx=%0d lvl=%0d e=%b, want 0 0 1", rd_idx, level, empty);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, 1'b0, mk(16'(16'h200 + i), 4'(i)));
            tests++;
            if (level !== 4'(sb.size()) || int_flag !== (sb.size() >= THR)) begin
                fails++; $display("FAIL wrap_level: got lvl=%0d int=%b, want %0d %b", level, int_flag, sb.size(), sb.size() >= THR);
            end
            if (sb.size() >= 4) begin
                drain_one("wrap_drain");
                drain_one("wrap_drain");
            end
        end
        while (sb.size() != 0) drain_one("wrap_final");
        tests++;
        if (empty !== 1'b1 || int_flag !== 1'b0) begin
            fails++; $display("FAIL wrap_end: got e=%b int=%b, want 1 0", empty, int_flag);
        end
    endtask

    task automatic test_reset_midread();
        cycle(1'b1, 1'b0, 1'b0, mk(16'h0300, 4'h2));
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        rtc_rst_n = 1'b0;
        #2;
        sb.delete(); exp_idx = 0; movf = '0;
        tests++;
        if (rd_idx !== 3'd0 || level !== 4'd0 || empty !== 1'b1 || rd_data !== 32'h0) begin
            fails++; $display("FAIL reset_midread: got idx=%0d lvl=%0d e=%b data=%h, want 0 0 1 0", rd_idx, level, empty, rd_data);
        end
        @(posedge rtc_clk); #1;
        rtc_rst_n = 1'b1;
    endtask

`ifdef PTP_TS_FIFO_MSG_FILTER_EN
    task automatic test_msg_filter();
        msg_filter = 16'h0001;
        cycle(1'b1, 1'b0, 1'b0, mk(16'h0400, 4'h0));
        cycle(1'b1, 1'b0, 1'b0, mk(16'h0401, 4'h1));
        tests++;
        if (level !== 4'd1 || ovf_cnt !== 16'd0) begin
            fails++; $display("FAIL msg_filter: got lvl=%0d ovf=%0d, want 1 0", level, ovf_cnt);
        end
        drain_one("msg_filter_drain");
        msg_filter = 16'hFFFF;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tests = 0; fails = 0; exp_idx = 0; movf = '0;
        wr_en = 1'b0; rd_word = 1'b0; clr = 1'b0; din = '0;
`ifdef PTP_TS_FIFO_MSG_FILTER_EN
        msg_filter = 16'hFFFF;
`endif
        rtc_rst_n = 1'b1;
        #1 rtc_rst_n = 1'b0;
        #2;
        test_reset();
        repeat (2) @(posedge rtc_clk);
        #1 rtc_rst_n = 1'b1;
        test_single_record();
        test_overflow();
        test_full_pop_push();
        test_clear();
        test_empty_read();
        test_wrap();
        test_reset_midread();
`ifdef PTP_TS_FIFO_MSG_FILTER_EN
        test_msg_filter();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ptp_ts_fifo.md
Name: ptp_ts_fifo

Overview:
- Downstream consumer of the rx or tx timestamp record produced by the timestamp unit, in the rtc_clk domain. Instantiated once per direction.
- Queues each captured PTP record (timestamp, fractional ns, identification fields) in a DEPTH-entry FIFO so software does not lose back-to-back events.
- Software drains the FIFO as seven 32-bit words per record through a word-sequential read port.
- Provides level, overflow and interrupt status.

Parameters:
DEPTH, 8, number of record entries; power of 2, range 2..64
AW, 3, pointer width = log2(DEPTH); must match DEPTH
INT_THRESH, 1, level at or above which int_o asserts; range 1..DEPTH

Ports:
rtc_clk  in  1  block clock
rtc_rst_n  in  1  reset, asynchronous, active-low
wr_en_i  in  1  one-cycle pulse; record fields are valid this cycle
ts_i  in  80  timestamp {48b seconds, 32b ns}
ts_frac_ns_i  in  16  fractional nanoseconds
src_port_id_i  in  80  sourcePortIdentity
seq_id_i  in  16  sequenceId
flag_field_i  in  16  flagField
msg_type_i  in  4  messageType
major_sdo_id_i  in  4  majorSdoId
rd_word_i  in  1  pulse; consume the current word of the head record
clr_i  in  1  synchronous flush
rd_data_o  out  32  current word of the head record
rd_word_idx_o  out  3  index 0..6 of the word on rd_data_o
level_o  out  AW+1  number of stored records
empty_o  out  1  level_o == 0
full_o  out  1  level_o == DEPTH
ovf_cnt_o  out  16  count of records dropped due to full; saturating
int_o  out  1  level_o >= INT_THRESH

Behaviour:
- Reset values: all pointers, level_o, rd_word_idx_o and ovf_cnt_o are 0. empty_o=1, full_o=0, int_o=0, rd_data_o=0. Storage array is not reset.
- Clock and reset: single clock rtc_clk; rtc_rst_n is asynchronous assert, active-low. Reset mid-read abandons the partial record.
- Record word map:
  - w0 = ts[79:48]
  - w1 = ts[47:16]
  - w2 = {ts[15:0], frac_ns}
  - w3 = spid[79:48]
  - w4 = spid[47:16]
  - w5 = {spid[15:0], seq_id}
  - w6 = {flag_field, 8'h00, major_sdo_id, msg_type}
- Write:
  - wr_en_i with not full: record stored at the write pointer. Write pointer +1, wrapping at DEPTH-1 -> 0.
  - Status latency: level_o, empty_o, full_o and int_o update on the next edge.
- Read:
  - rd_data_o is combinational from the head entry, selected by rd_word_idx_o; it is 0 while empty.
  - rd_word_i when not empty: idx 0..5 -> idx+1. At idx 6 -> idx 0, head popped, read pointer +1 (wrapping).
  - rd_word_i while empty: ignored; no state change.
- Full:
  - wr_en_i while full and no same-cycle pop: record dropped, ovf_cnt_o +1, saturating at 16'hFFFF.
  - wr_en_i while full with a same-cycle pop (rd_word_i at idx 6): record accepted, level unchanged, ovf unchanged.
- Simultaneous write and pop when not full: both performed, level unchanged.
- Write into an empty FIFO: rd_data_o shows w0 of the new record from the next cycle.
- clr_i (highest priority):
  - Next edge: pointers, level, rd_word_idx_o and ovf_cnt_o go to 0.
  - Any same-cycle wr_en_i or rd_word_i is ignored; a dropped write is not counted.
- Level arithmetic is AW+1 bits and never exceeds DEPTH. Pointers are AW bits with natural wrap.

Optional Feature:
PTP_TS_FIFO_MSG_FILTER_EN:
- Defined:
  - Extra input msg_filter_i [15:0], a per-messageType enable mask.
  - A wr_en_i whose bit msg_filter_i[msg_type_i] is 0 is discarded silently: no store, no ovf_cnt_o increment.
  - Filtered writes are evaluated before the full check.
- Undefined: port absent; every wr_en_i is a write candidate.

Test Plan:
- Write one record (ts=80'h0000_0000_0001_1234_5678, frac=16'hABCD, seq=16'h0007, msg=4'h0), then seven rd_word_i -> words w0..w6 match the map (w2=32'h5678ABCD); then empty_o=1, rd_data_o=0.
- DEPTH=8: write 10 records with no reads -> full_o=1, level_o=8, ovf_cnt_o=2. Read-out returns seq ids of the first 8 in order.
- FIFO full, rd_word_i at idx 6 and wr_en_i in the same cycle -> level stays 8, ovf_cnt_o unchanged, new record readable last.
- Half-read record (idx=3), then clr_i=1 together with wr_en_i -> level_o=0, idx=0, ovf_cnt_o=0, no record stored.
- rd_word_i while empty -> idx stays 0, level_o stays 0. 20 write/read cycles over pointer wrap -> data intact; int_o tracks level_o>=INT_THRESH.
- PTP_TS_FIFO_MSG_FILTER_EN with msg_filter_i=16'h0001: write msg 0 and msg 1 -> only the msg 0 record is stored, ovf_cnt_o=0.
